// File: rtl/arith_unit_pkg.sv
// Shared constants and types for the sign-magnitude arithmetic unit.
package au_pkg;

    localparam int AU_W    = 24;
    localparam int AU_FRAC = 14;
    localparam int MAG_MAX = (1 << (AU_W - 1)) - 1;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam logic [1:0] YSEL_S     = 2'b00;
    localparam logic [1:0] YSEL_IMM   = 2'b01;
    localparam logic [1:0] YSEL_RECIP = 2'b10;

    typedef enum logic [1:0] {IDLE, RECIP, MUL, FIN} state_e;

endpackage

// File: rtl/arith_unit_if.sv
// Sequencer-facing request/response bundle of the arithmetic unit.
interface arith_unit_if #(
    parameter int W = 24
);
    logic         start;
    logic [W-1:0] R_in;
    logic [W-1:0] S_in;
    logic [W-1:0] Iimm_in;
    logic [1:0]   op_sel;
    logic [1:0]   mul_y_sel;
    logic [W-1:0] result;
    logic         done;
    logic         busy;

    modport master (
        output start, R_in, S_in, Iimm_in, op_sel, mul_y_sel,
        input  result, done, busy
    );

    modport slave (
        input  start, R_in, S_in, Iimm_in, op_sel, mul_y_sel,
        output result, done, busy
    );
endinterface

// File: rtl/arith_unit_recip.sv
// Iterative restoring divider producing the sign-magnitude reciprocal 2^(2*FRAC)/|divisor|.
// AU_ROUND_EN rounds the last quotient bit from the final remainder.
module au_recip
    import au_pkg::*;
#(
    parameter int W    = AU_W,
    parameter int FRAC = AU_FRAC
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic         run,
    output logic         rdy
);
    localparam int MW = W - 1;
    localparam int CW = $clog2(MW);
    // Dividend bits above the quotient window; all lower dividend bits are zero.
    localparam logic [W-1:0] REM_INIT = W'(1) << (2 * FRAC - MW);

    logic [MW-1:0] d_q, q_q, q_d;
    logic [W-1:0]  rem_q, rem_d, rem_sh;
    logic [CW-1:0] cnt_q;
    logic          sign_q, sat_q, run_q, ge;

    assign rdy      = run_q && (cnt_q == CW'(MW - 1));
    assign run      = run_q;
    assign quotient = {sign_q, sat_q ? {MW{1'b1}} : q_q};

    always_comb begin
        rem_sh = {rem_q[W-2:0], 1'b0};
        ge     = (rem_sh >= {1'b0, d_q});
        rem_d  = ge ? (rem_sh - {1'b0, d_q}) : rem_sh;
        q_d    = {q_q[MW-2:0], ge};
`ifdef AU_ROUND_EN
        if (rdy && ({rem_d[W-2:0], 1'b0} >= {1'b0, d_q}) && (q_d != {MW{1'b1}}))
            q_d = q_d + MW'(1);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q    <= '0;
            q_q    <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            sign_q <= 1'b0;
            sat_q  <= 1'b0;
            run_q  <= 1'b0;
        end else if (start) begin
            d_q    <= divisor[W-2:0];
            sign_q <= divisor[W-1];
            // A divisor no larger than the initial remainder overflows the quotient (covers zero).
            sat_q  <= (divisor[W-2:0] <= REM_INIT[W-2:0]);
            rem_q  <= REM_INIT;
            q_q    <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b1;
        end else if (run_q) begin
            rem_q <= rem_d;
            q_q   <= q_d;
            cnt_q <= cnt_q + CW'(1);
            if (rdy)
                run_q <= 1'b0;
        end
    end

endmodule

// File: rtl/arith_unit.sv
// Sign-magnitude fixed-point ADD/SUB/MUL in one cycle, DIV via the iterative reciprocal.
// Define AU_ROUND_EN for round-half-up multiplication and a rounded reciprocal.
module arith_unit
    import au_pkg::*;
#(
    parameter int W    = AU_W,
    parameter int FRAC = AU_FRAC
) (
    input  logic        clk,
    input  logic        rst_n,
    arith_unit_if.slave bus
);
    localparam int MW = W - 1;
    localparam int PW = 2 * MW;
    localparam logic [MW-1:0] MAG_SAT = '1;

    state_e       state, state_d;
    logic         recip_start, recip_run, recip_rdy, use_recip, accept;
    logic [W-1:0] x_q, s_q, result_q, recip_q, y_sel;

    function automatic logic [W-1:0] sm_pack(input logic s, input logic [MW-1:0] m);
        return {s & (m != '0), m};
    endfunction

    function automatic logic [W-1:0] add_sm(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic neg_y);
        logic          sx, sy, s;
        logic [MW-1:0] mx, my, m;
        logic [W-1:0]  sum;
        sx  = x[W-1];
        sy  = y[W-1] ^ neg_y;
        mx  = x[MW-1:0];
        my  = y[MW-1:0];
        sum = {1'b0, mx} + {1'b0, my};
        if (sx == sy) begin
            m = sum[W-1] ? MAG_SAT : sum[MW-1:0];
            s = sx;
        end else if (mx >= my) begin
            m = mx - my;
            s = sx;
        end else begin
            m = my - mx;
            s = sy;
        end
        return sm_pack(s, m);
    endfunction

    function automatic logic [W-1:0] mul_sm(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [PW-1:0] prod, shifted;
        logic [MW-1:0] m;
        prod = PW'(x[MW-1:0]) * PW'(y[MW-1:0]);
`ifdef AU_ROUND_EN
        prod = prod + (PW'(1) << (FRAC - 1));
`endif
        shifted = prod >> FRAC;
        m = (|shifted[PW-1:MW]) ? MAG_SAT : shifted[MW-1:0];
        return sm_pack(x[W-1] ^ y[W-1], m);
    endfunction

    assign accept    = (state == IDLE) && bus.start;
    assign use_recip = (bus.op_sel == OP_DIV) ||
                       ((bus.op_sel == OP_MUL) && (bus.mul_y_sel == YSEL_RECIP));

    // ADD/SUB with the reciprocal select take the reciprocal left by the last divide.
    always_comb begin
        y_sel = bus.S_in;
        case (bus.mul_y_sel)
            YSEL_IMM:   y_sel = bus.Iimm_in;
            YSEL_RECIP: y_sel = recip_q;
            default:    y_sel = bus.S_in;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (bus.start) state_d = use_recip ? RECIP : FIN;
            RECIP:   if (recip_rdy) state_d = MUL;
            MUL:     state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == RECIP) || (state == MUL) || recip_run;
        bus.done = (state == FIN);
    end

    assign bus.result = result_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q         <= '0;
            s_q         <= '0;
            result_q    <= '0;
            recip_start <= 1'b0;
        end else begin
            recip_start <= accept && use_recip;
            if (accept) begin
                x_q <= bus.R_in;
                s_q <= bus.S_in;
            end
            if (accept && !use_recip)
                result_q <= (bus.op_sel == OP_MUL) ? mul_sm(bus.R_in, y_sel)
                                                   : add_sm(bus.R_in, y_sel, bus.op_sel == OP_SUB);
            else if (state == MUL)
                result_q <= mul_sm(x_q, recip_q);
        end
    end

    au_recip #(.W(W), .FRAC(FRAC)) Mult_Inv (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (recip_start),
        .divisor  (s_q),
        .quotient (recip_q),
        .run      (recip_run),
        .rdy      (recip_rdy)
    );

endmodule

// File: tb/tb_arith_unit.sv
// Randomized scoreboard bench for arith_unit against an integer-arithmetic reference model.
module tb_arith_unit;
    import au_pkg::*;

    localparam int W    = AU_W;
    localparam int FRAC = AU_FRAC;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    arith_unit_if #(.W(W)) bus ();

    arith_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] res;
        int           cyc;
        string        tag;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic longint mag(input logic [W-1:0] v);
        return longint'(v[W-2:0]);
    endfunction

    function automatic logic [W-1:0] sm(input bit s, input longint m);
        return {s && (m != 0), (W-1)'(m)};
    endfunction

    function automatic logic [W-1:0] m_add(input logic [W-1:0] x, input logic [W-1:0] y, input bit neg);
        longint vx, vy, s, m;
        vx = x[W-1] ? -mag(x) : mag(x);
        vy = (y[W-1] ^ neg) ? -mag(y) : mag(y);
        s  = vx + vy;
        m  = (s < 0) ? -s : s;
        if (m > MAG_MAX) m = MAG_MAX;
        return sm(s < 0, m);
    endfunction

    function automatic logic [W-1:0] m_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        longint p;
        p = mag(x) * mag(y);
`ifdef AU_ROUND_EN
        p = p + (longint'(1) << (FRAC - 1));
`endif
        p = p >> FRAC;
        if (p > MAG_MAX) p = MAG_MAX;
        return sm(x[W-1] ^ y[W-1], p);
    endfunction

    function automatic logic [W-1:0] m_recip(input logic [W-1:0] s);
        longint d, n, m;
        d = mag(s);
        n = longint'(1) << (2 * FRAC);
        if (d <= (n >> (W - 1))) begin
            m = MAG_MAX;
        end else begin
            m = n / d;
`ifdef AU_ROUND_EN
            if (2 * (n % d) >= d) m = m + 1;
            if (m > MAG_MAX) m = MAG_MAX;
`endif
        end
        return {s[W-1], (W-1)'(m)};
    endfunction

    function automatic logic [W-1:0] model(input logic [1:0] op, input logic [1:0] ysel,
                                           input logic [W-1:0] r, input logic [W-1:0] s,
                                           input logic [W-1:0] imm);
        logic [W-1:0] y;
        if (op == OP_DIV) return m_mul(r, m_recip(s));
        y = (ysel == YSEL_IMM) ? imm : (ysel == YSEL_RECIP) ? m_recip(s) : s;
        if (op == OP_MUL) return m_mul(r, y);
        return m_add(r, y, op == OP_SUB);
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n && bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: done at cycle %0d, expected no pending op", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                $display("txn %-12s result=%06h expected=%06h done_cycle=%0d expected_cycle=%0d",
                         mon_e.tag, bus.result, mon_e.res, cyc, mon_e.cyc);
                check({mon_e.tag, "_result"}, 64'(bus.result), 64'(mon_e.res));
                check({mon_e.tag, "_latency"}, 64'(cyc), 64'(mon_e.cyc));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic run_op(input string tag, input logic [1:0] op, input logic [1:0] ysel,
                          input logic [W-1:0] r, input logic [W-1:0] s, input logic [W-1:0] imm,
                          input bit poke_busy);
        bit slow;
        int e, nbusy, nrs, guard;
        exp_t ex;
        slow = (op == OP_DIV) || ((op == OP_MUL) && (ysel == YSEL_RECIP));
        @(negedge clk);
        bus.op_sel    = op;
        bus.mul_y_sel = ysel;
        bus.R_in      = r;
        bus.S_in      = s;
        bus.Iimm_in   = imm;
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        e      = cyc;
        ex.res = model(op, ysel, r, s, imm);
        ex.cyc = slow ? e + 25 : e;
        ex.tag = tag;
        exp_q.push_back(ex);
        bus.start     = 1'b0;
        bus.R_in      = W'($urandom);
        bus.S_in      = W'($urandom);
        bus.Iimm_in   = W'($urandom);
        bus.op_sel    = 2'($urandom);
        bus.mul_y_sel = 2'($urandom);
        nbusy = 0;
        nrs   = 0;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
            if (bus.busy === 1'b1) nbusy++;
            if (dut.recip_start === 1'b1) nrs++;
            if (poke_busy && bus.busy === 1'b1 && guard < 20)
                bus.start = 1'($urandom_range(0, 1));
            else
                bus.start = 1'b0;
        end while ((bus.busy !== 1'b0 || bus.done !== 1'b0) && guard < 60);
        if (guard >= 60) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: still busy after %0d cycles, expected idle", tag, guard);
        end
        check({tag, "_busy_cycles"}, 64'(nbusy), slow ? 64'd25 : 64'd0);
        check({tag, "_recip_start"}, 64'(nrs), slow ? 64'd1 : 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]   op, ys;
        logic [W-1:0] r, s, imm;

        bus.start     = 1'b0;
        bus.R_in      = '0;
        bus.S_in      = '0;
        bus.Iimm_in   = '0;
        bus.op_sel    = '0;
        bus.mul_y_sel = '0;
        repeat (3) @(negedge clk);
        check("reset_result", 64'(bus.result), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_state", 64'(dut.state), 64'(IDLE));
        rst_n = 1'b1;

        run_op("div_1_1",   OP_DIV, 2'b00, 24'h004000, 24'h004000, 24'h0, 1'b0);
        run_op("div_1_2",   OP_DIV, 2'b00, 24'h004000, 24'h008000, 24'h0, 1'b0);
        run_op("div_1_4",   OP_DIV, 2'b01, 24'h004000, 24'h010000, 24'h0, 1'b0);
        run_op("div_1_8",   OP_DIV, 2'b11, 24'h004000, 24'h020000, 24'h0, 1'b0);
        run_op("div_1_m2",  OP_DIV, 2'b00, 24'h004000, 24'h808000, 24'h0, 1'b0);
        run_op("div_1_m4",  OP_DIV, 2'b00, 24'h004000, 24'h810000, 24'h0, 1'b0);
        run_op("div_s0",    OP_DIV, 2'b01, 24'h004000, 24'h000000, 24'h0, 1'b1);
        run_op("div_s32",   OP_DIV, 2'b00, 24'h004000, 24'h000020, 24'h0, 1'b0);
        run_op("div_s33",   OP_DIV, 2'b00, 24'h004000, 24'h800021, 24'h0, 1'b0);
        run_op("add_3_m5",  OP_ADD, 2'b00, 24'h00C000, 24'h814000, 24'h0, 1'b0);
        run_op("mul_2_m15", OP_MUL, 2'b01, 24'h008000, 24'h000000, 24'h806000, 1'b0);
        run_op("mul_recip", OP_MUL, 2'b10, 24'h00C000, 24'h010000, 24'h0, 1'b0);
        run_op("sub_zero",  OP_SUB, 2'b00, 24'h804000, 24'h804000, 24'h0, 1'b0);
        run_op("add_sat",   OP_ADD, 2'b11, 24'h7FFFFF, 24'h000001, 24'h0, 1'b0);
        run_op("mul_sat",   OP_MUL, 2'b00, 24'h7FFFFF, 24'h87FFFF, 24'h0, 1'b0);

        // Abort a divide with reset: no done, outputs cleared, next op unaffected.
        @(negedge clk);
        bus.op_sel = OP_DIV;
        bus.R_in   = 24'h00C000;
        bus.S_in   = 24'h004000;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_done", 64'(bus.done), 64'd0);
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_result", 64'(bus.result), 64'd0);
        check("abort_state", 64'(dut.state), 64'(IDLE));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        run_op("post_abort", OP_DIV, 2'b00, 24'h004000, 24'h808000, 24'h0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            op  = 2'($urandom_range(0, 3));
            ys  = 2'($urandom_range(0, 3));
            if (op < 2 && ys == YSEL_RECIP) ys = YSEL_S;
            r   = W'($urandom);
            s   = W'($urandom);
            imm = W'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                r   = r & 24'h80FFFF;
                imm = imm & 24'h80FFFF;
            end
            if ($urandom_range(0, 5) == 0) s = s & 24'h80003F;
            run_op($sformatf("rnd%0d", i), op, ys, r, s, imm, 1'($urandom_range(0, 1)));
        end

        repeat (4) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/arith_unit.md
Name: arith_unit

Overview:
- Sign-magnitude fixed-point arithmetic unit: ADD, SUB and MUL complete in one cycle; DIV (R × 1/S) runs through an iterative reciprocal.
- Datapath leaf block of the Kalman-filter ASIC, driven by the sequencer with start, done and busy.
- Word format: bit W-1 is the sign, bits W-2:0 are the magnitude with FRAC fraction bits (S9.14 at defaults).

Parameters:
- W, 24, word width including the sign bit.
- FRAC, 14, number of fraction bits in the magnitude.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- R_in  in  W  operand x.
- S_in  in  W  operand y source / divisor.
- Iimm_in  in  W  immediate y source.
- op_sel  in  2  00 ADD, 01 SUB, 10 MUL, 11 DIV.
- mul_y_sel  in  2  y for ADD/SUB/MUL: 00 S_in, 01 Iimm_in, 10 recip(S_in), 11 S_in.
- result  out  W  last result; held until the next completion.
- done  out  1  one-cycle pulse when result updates.
- busy  out  1  high while a multi-cycle operation is in flight.

Behaviour:
- Reset: state IDLE; result=0, done=0, busy=0; reciprocal engine cleared.
- A reset asserted mid-operation aborts the operation with no done pulse.
- Operands and opcode are latched at the start edge. Input changes after that edge have no effect.
- start while busy is ignored.
- States: IDLE, RECIP, MUL, FIN.
  - Single-cycle path: IDLE + start with op ADD/SUB, or MUL with y≠recip. Result registered at the start edge (next-state FIN). done=1 for the cycle after that edge. Return to IDLE.
  - Reciprocal path: DIV, or MUL with mul_y_sel=10. IDLE → RECIP; busy=1 from the following cycle.
  - RECIP: engine resolves one quotient bit per cycle over W-1=23 cycles, then goes to MUL.
  - MUL: one cycle. Multiplies x by the reciprocal. Goes to FIN with result registered and done=1, busy=0.
- DIV ignores mul_y_sel and always uses recip(S_in).
- DIV latency: done asserted 25 clock edges after the start edge. Fixed for every operand value.
- Reciprocal magnitude = floor(2^(2·FRAC) / |S|), computed by restoring division. Sign = sign of S.
- If |S| raw ≤ 2^(2·FRAC-(W-1)) (=32), the quotient does not fit. Magnitude saturates to 2^(W-1)-1; this also covers S=0. Timing is unchanged.
- ADD/SUB:
  - SUB flips the sign of y.
  - Same signs: add magnitudes. Otherwise subtract the smaller magnitude from the larger and take the larger operand's sign.
  - A magnitude overflow saturates to 2^(W-1)-1.
- MUL:
  - Magnitude = (|x|·|y|) >> FRAC, truncated. Saturates to 2^(W-1)-1.
  - Sign = sign(x) XOR sign(y).
- Any zero magnitude result is emitted as +0 (sign=0).
- Reciprocal engine handshake, all signals observable:
  - recip_start is a one-cycle pulse on entering RECIP.
  - run is high while iterating.
  - rdy pulses on the last iteration.

Optional Feature:
- AU_ROUND_EN.
- Defined: MUL adds 2^(FRAC-1) before the shift (round-half-up on magnitude), and the reciprocal rounds its final quotient bit by remainder comparison. Saturation still applies.
- Undefined: truncation everywhere, as above.

Decomposition:
- Package au_pkg holds:
  - op codes OP_ADD/OP_SUB/OP_MUL/OP_DIV;
  - y-select codes YSEL_S/YSEL_IMM/YSEL_RECIP;
  - the state enum;
  - MAG_MAX = 2^(W-1)-1.
- One sub-module, au_recip: an iterative restoring divider with ports clk, rst_n, start, divisor[W-1:0], quotient[W-1:0], run, rdy. Its instance name is Mult_Inv.
- The top instance signals recip_start and state are directly accessible.

Test Plan:
- DIV, R=1.0 (0x004000), S=1.0 (0x004000) → result 0x004000. done exactly 25 edges after start; busy high throughout.
- DIV, R=1.0, S=2/4/8 → 0x002000 / 0x001000 / 0x000800; each within 10% of 0.5/0.25/0.125.
- DIV, R=1.0, S=-2 (0x808000) → 0x802000 (-0.5); S=-4 → 0x801000.
- DIV, S=0 → result 0x7FFFFF; latency still 25; start pulses during busy are ignored.
- ADD, R=3.0 (0x00C000), S=-5.0 (0x814000), mul_y_sel=00 → 0x808000 (-2.0); done the cycle after start; busy stays 0.
- MUL, R=2.0, Iimm=-1.5, mul_y_sel=01 → 0x80C000. rst_n pulled low mid-DIV → done/busy/result 0, and the next op runs normally.
